// File: rtl/rr_arbiter_4_if.sv
// Request/grant bundle between the requesting blocks and the round-robin arbiter.
// The master drives requests; the slave (the arbiter) returns the grant.
interface rr_arbiter_4_if;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;

  modport master (output req, input gnt, input gnt_idx, input gnt_valid);
  modport slave  (input req, output gnt, output gnt_idx, output gnt_valid);
endinterface

// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with registered one-hot grant, binary owner index
// and a hold limit that forces rotation when a long-running owner is contended.
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  rr_arbiter_4_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} state_t;

  // With no limit the counter simply parks at all-ones.
  localparam int SatInt = (MAX_HOLD == 0) ? (2 ** CNT_W) - 1 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_SAT = CNT_W'(SatInt);

  state_t           r_state;
  logic [1:0]       r_last;
  logic [CNT_W-1:0] r_hold_cnt;
  logic [3:0]       r_gnt;
  logic [1:0]       r_gnt_idx;
  logic             r_gnt_valid;

  state_t           w_next_state;
  logic [1:0]       w_next_last;
  logic [CNT_W-1:0] w_next_hold_cnt;
  logic [3:0]       w_next_gnt;
  logic [1:0]       w_next_idx;
  logic             w_next_valid;
  logic             w_take;
  logic [3:0]       w_mask;
  logic [1:0]       w_winner;
  logic [3:0]       w_owner_mask;
  logic [3:0]       w_others;
  logic             w_owner_req;
  logic             w_limit_hit;

  // Candidates are ptr+1, ptr+2, ptr+3, ptr; scanning backwards keeps the earliest hit.
  function automatic logic [1:0] rrPick(input logic [3:0] mask, input logic [1:0] ptr);
    logic [1:0] cand;
    logic [1:0] pick;
    pick = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (mask[cand]) pick = cand;
    end
    return pick;
  endfunction

  assign w_owner_mask = 4'b0001 << r_gnt_idx;
  assign w_others     = bus.req & ~w_owner_mask;
  assign w_owner_req  = bus.req[r_gnt_idx];
  assign w_limit_hit  = (MAX_HOLD != 0) && (r_hold_cnt == HOLD_SAT) && (|w_others);
  assign w_winner     = rrPick(w_mask, r_last);

  always_comb begin
    w_next_state    = r_state;
    w_next_last     = r_last;
    w_next_hold_cnt = r_hold_cnt;
    w_next_idx      = r_gnt_idx;
    w_next_valid    = r_gnt_valid;
    w_take          = 1'b0;
    w_mask          = bus.req;

    case (r_state)
      IDLE: begin
        if (|bus.req) w_take = 1'b1;
      end
      BUSY: begin
        // A release takes priority over a simultaneous forced rotation.
        if (!w_owner_req) begin
          if (|bus.req) begin
            w_take = 1'b1;
          end else begin
            w_next_state = IDLE;
            w_next_valid = 1'b0;
          end
        end else if (w_limit_hit) begin
          w_take = 1'b1;
          w_mask = w_others;
        end else if (r_hold_cnt != HOLD_SAT) begin
          w_next_hold_cnt = r_hold_cnt + CNT_W'(1);
        end
      end
      default: w_next_state = IDLE;
    endcase

    if (w_take) begin
      w_next_state    = BUSY;
      w_next_idx      = w_winner;
      w_next_last     = w_winner;
      w_next_hold_cnt = '0;
      w_next_valid    = 1'b1;
    end

    w_next_gnt = w_next_valid ? (4'b0001 << w_next_idx) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_last      <= 2'd3;
      r_hold_cnt  <= '0;
      r_gnt       <= 4'b0000;
      r_gnt_idx   <= 2'b00;
      r_gnt_valid <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_last      <= w_next_last;
      r_hold_cnt  <= w_next_hold_cnt;
      r_gnt       <= w_next_gnt;
      r_gnt_idx   <= w_next_idx;
      r_gnt_valid <= w_next_valid;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.gnt_idx   = r_gnt_idx;
  assign bus.gnt_valid = r_gnt_valid;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed request patterns checked against a cycle-level
// owner/last/held-cycles model plus literal expectations at key points.
module tb_rr_arbiter_4;

  localparam int MaxHold = 8;

  logic clk;
  logic rst_n;
  rr_arbiter_4_if bus ();

  rr_arbiter_4 #(.MAX_HOLD(MaxHold), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int assertCount = 0;
  int failCount   = 0;

  // Model: current owner (-1 when idle), last winner, cycles the owner has shown its grant.
  int         mOwner = -1;
  int         mLast  = 3;
  int         mHeld  = 0;
  logic [1:0] mIdx   = 2'd0;

  function automatic int pickNext(input logic [3:0] mask, input int from);
    for (int k = 1; k <= 4; k++) begin
      if (mask[(from + k) % 4]) return (from + k) % 4;
    end
    return -1;
  endfunction

  task automatic modelGrant(input int who);
    mOwner = who;
    mLast  = who;
    mIdx   = 2'(who);
    mHeld  = 1;
  endtask

  always @(posedge clk or negedge rst_n) begin
    logic [3:0] others;
    if (!rst_n) begin
      mOwner = -1;
      mLast  = 3;
      mHeld  = 0;
      mIdx   = 2'd0;
    end else if (mOwner < 0) begin
      if (bus.req != 4'b0000) modelGrant(pickNext(bus.req, mLast));
    end else if (!bus.req[mOwner]) begin
      if (bus.req != 4'b0000) modelGrant(pickNext(bus.req, mLast));
      else mOwner = -1;
    end else begin
      others = bus.req;
      others[mOwner] = 1'b0;
      if (MaxHold != 0 && mHeld >= MaxHold && others != 4'b0000)
        modelGrant(pickNext(others, mOwner));
      else
        mHeld++;
    end
  end

  // Every cycle out of reset, compare the DUT against the model.
  always @(negedge clk) begin
    logic [3:0] expGnt;
    if (rst_n) begin
      expGnt = (mOwner < 0) ? 4'b0000 : (4'b0001 << mOwner);
      assertCount++;
      if (bus.gnt !== expGnt) begin
        failCount++;
        $display("[TB] FAIL model_gnt at %0t: got %b expected %b", $time, bus.gnt, expGnt);
      end
      assertCount++;
      if (bus.gnt_valid !== (mOwner >= 0)) begin
        failCount++;
        $display("[TB] FAIL model_valid at %0t: got %b expected %b", $time, bus.gnt_valid, (mOwner >= 0));
      end
      assertCount++;
      if (bus.gnt_idx !== mIdx) begin
        failCount++;
        $display("[TB] FAIL model_idx at %0t: got %0d expected %0d", $time, bus.gnt_idx, mIdx);
      end
      assertCount++;
      if (!$onehot0(bus.gnt)) begin
        failCount++;
        $display("[TB] FAIL onehot at %0t: got %b expected at most one bit", $time, bus.gnt);
      end
    end
  end

  task automatic applyStimulus(input logic [3:0] reqVal, input int cycles);
    bus.req = reqVal;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input logic [3:0] expGnt, input string name);
    assertCount++;
    if (bus.gnt !== expGnt || bus.gnt_valid !== (|expGnt)) begin
      failCount++;
      $display("[TB] FAIL %s: got gnt=%b valid=%b expected gnt=%b valid=%b",
               name, bus.gnt, bus.gnt_valid, expGnt, |expGnt);
    end
    if (expGnt != 4'b0000) begin
      assertCount++;
      if (bus.gnt_idx !== 2'($clog2(expGnt))) begin
        failCount++;
        $display("[TB] FAIL %s_idx: got %0d expected %0d", name, bus.gnt_idx, $clog2(expGnt));
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] fairReq;
    rst_n   = 1'b0;
    bus.req = 4'b1111;

    $display("[TB] reset with all requests high");
    applyStimulus(4'b1111, 3);
    checkOutput(4'b0000, "reset_gnt");
    rst_n = 1'b1;
    applyStimulus(4'b1111, 1);
    checkOutput(4'b0001, "first_grant");

    $display("[TB] round-robin fairness");
    for (int i = 0; i < 8; i++) begin
      checkOutput(4'b0001 << (i % 4), $sformatf("fair_%0d", i));
      applyStimulus(4'b1111, 1);
      fairReq = 4'b1111;
      fairReq[i % 4] = 1'b0;
      applyStimulus(fairReq, 1);
    end
    checkOutput(4'b0001, "fair_wrap");
    applyStimulus(4'b0000, 2);
    checkOutput(4'b0000, "idle_after_fair");

    $display("[TB] hold limit");
    bus.req = 4'b0001;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput(4'b0001, $sformatf("hold_%0d", c));
      if (c == 3) bus.req = 4'b0101;
    end
    @(negedge clk);
    checkOutput(4'b0100, "hold_rotate");
    applyStimulus(4'b0000, 1);
    checkOutput(4'b0000, "idle_after_hold");

    $display("[TB] uncontended hold");
    bus.req = 4'b1000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      checkOutput(4'b1000, $sformatf("solo_%0d", c));
    end
    applyStimulus(4'b0000, 1);
    checkOutput(4'b0000, "solo_release");

    $display("[TB] wrap-around and skip");
    applyStimulus(4'b0110, 1);
    checkOutput(4'b0010, "wrap_skip");
    applyStimulus(4'b0100, 1);
    checkOutput(4'b0100, "direct_handoff");

    $display("[TB] asynchronous reset mid-grant");
    #1 rst_n = 1'b0;
    #1 checkOutput(4'b0000, "async_reset");
    #1 rst_n = 1'b1;
    applyStimulus(4'b1100, 1);
    checkOutput(4'b0100, "post_reset_grant");

    $display("[TB] sustained contention");
    applyStimulus(4'b1111, 30);
    applyStimulus(4'b0000, 2);
    checkOutput(4'b0000, "final_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- 4-requester round-robin arbiter for a shared resource selected by the team's 2-to-4 decoder.
- Encodes the winner as a 2-bit index and decodes it internally to a registered one-hot grant.
- Adds a per-grant hold limit so one requester cannot starve the others.
- Sits between requesting blocks and the shared datapath; gnt_idx drives the resource select lines.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles a grant is held while other requests are pending. Range 1..2**CNT_W. 0 = no limit.
- CNT_W, 4: width of the internal hold counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  4  request vector; req[i] = requester i wants the resource; level, held high for the whole transaction
- gnt  output  4  registered one-hot grant; all-zero when idle
- gnt_idx  output  2  binary index of the current owner; valid only when gnt_valid=1
- gnt_valid  output  1  high while any grant is active

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low.
- Reset values while rst_n=0, with immediate effect:
  - gnt=4'b0000, gnt_idx=2'b00, gnt_valid=0.
  - State=IDLE, hold_cnt=0.
  - Last-owner pointer last=2'd3, so requester 0 has highest priority after reset.
- States:
  - IDLE: no owner.
  - BUSY: owner = gnt_idx.
- Round-robin search: candidates in order last+1, last+2, last+3, last, modulo 4 (2-bit wrap). The first candidate with req high wins.
- IDLE -> BUSY:
  - Occurs on the first edge where req != 0.
  - gnt, gnt_idx and gnt_valid are updated at that edge. Latency: 1 cycle from req sampled to grant visible.
  - last <= winner; hold_cnt <= 0.
- BUSY, owner still requesting (req[owner]=1):
  - If MAX_HOLD=0, or hold_cnt < MAX_HOLD-1, or no other req bit set: keep the grant. hold_cnt increments, saturating at MAX_HOLD-1.
  - If hold_cnt = MAX_HOLD-1 and another req bit is set: forced rotation. Grant moves to the round-robin winner among the other requesters, excluding the owner. last <= winner; hold_cnt <= 0.
  - Result: an owner holds at most MAX_HOLD consecutive cycles when contended.
- BUSY, owner releases (req[owner]=0 sampled):
  - If another request is pending: grant moves directly to the round-robin winner at the same edge, with no idle bubble. last <= winner; hold_cnt <= 0.
  - Otherwise: go to IDLE. gnt=0, gnt_valid=0, gnt_idx keeps its last value. last is unchanged.
- Invariants:
  - gnt is the decode of gnt_idx when gnt_valid=1, else 0.
  - gnt is never more than one-hot.
  - gnt_valid = |gnt.
- Simultaneous events:
  - Owner release and a new request on the same edge: the new request is considered; normal search order applies.
  - Forced rotation and owner release on the same edge: treat as a release.
- A requester raising req while another owns the resource waits. Dropping req before being granted is legal and leaves no trace.
- Reset mid-grant: grant is removed asynchronously. After release, arbitration restarts from last=3.
- All outputs are driven from registers; no combinational path from req to outputs.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst_n=0 for 3 cycles with req=4'b1111, then release.
  - Required: gnt=0 during reset. One cycle after release, gnt=4'b0001, gnt_idx=0, gnt_valid=1.
- Round-robin fairness:
  - Stimulus: req=4'b1111; each owner drops its req bit after 2 cycles of grant, then re-raises it the next cycle.
  - Required: grant order 0,1,2,3,0,... with no cycle where gnt_valid=0.
- Hold limit:
  - Stimulus: MAX_HOLD=8; req=4'b0001 granted; at grant cycle 3 raise req[2]; req[0] stays high.
  - Required: gnt=4'b0001 for exactly 8 cycles, then gnt=4'b0100 on the next edge.
- Uncontended hold:
  - Stimulus: req=4'b1000 only, held 20 cycles.
  - Required: gnt=4'b1000 for all 20 cycles; hold_cnt saturates with no rotation. One cycle after req drops: gnt=0, gnt_valid=0.
- Wrap-around and skip:
  - Stimulus: after owner 3 releases, req=4'b0110.
  - Required: next grant is 4'b0010 (index 1). After it releases with req=4'b0100, grant moves directly to 4'b0100.
- Asynchronous reset mid-grant:
  - Stimulus: while gnt=4'b0100, pulse rst_n low between clock edges.
  - Required: gnt drops to 0 immediately, without waiting for a clock edge. After release with req=4'b1100, grant is 4'b0100, since last=3 and the search starts at index 0.
